imm_narrow_buffer: RTL and testbench

- Inverse of the immediate zero-extension path: narrows IN_W-bit datapath words back to OUT_W-bit immediate fields for encoding and store-back.
- Checks each narrowing for loss of information under zero- or sign-extension rules.
- Buffers results in a small ready/valid FIFO so the producing pipeline stage is decoupled from the consumer.
- Keeps a saturating count of lossy narrowings for debug.

---
 rtl/imm_narrow_buffer.sv | 104 ++++++++++
 tb/tb_imm_narrow_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/imm_narrow_buffer.sv
// Narrows wide datapath words to immediate fields, flags lossy narrowings,
// and buffers the results in a small ready/valid FIFO.
module imm_narrow_buffer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 10,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_lossy,
  input  logic             clr_count,
  output logic [CNT_W-1:0] lossy_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_OCC = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // A narrowing is lossy when the upper bits are not the extension of the field.
  function automatic logic f_lossy(input logic [IN_W-1:0] d, input logic sext);
    logic [IN_W-OUT_W-1:0] hi;
    hi = d[IN_W-1:OUT_W];
    if (sext) begin
      f_lossy = (hi != {(IN_W-OUT_W){d[OUT_W-1]}});
    end else begin
      f_lossy = |hi;
    end
  endfunction

  logic [OUT_W:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_occ;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_lossy;

  // Handshake qualifiers derive only from stored occupancy.
  always_comb begin
    w_in_ready  = (r_occ != FULL_OCC);
    w_out_valid = (r_occ != {CW{1'b0}});
    w_push      = in_valid & w_in_ready;
    w_pop       = w_out_valid & out_ready;
    w_lossy     = f_lossy(in_data, in_sext);
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_lossy, in_data[OUT_W-1:0]};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Saturating lossy counter; clear beats a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr_count) begin
      r_cnt <= '0;
    end else if (w_push && w_lossy && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = r_mem[r_rd_ptr][OUT_W-1:0];
  assign out_lossy   = r_mem[r_rd_ptr][OUT_W];
  assign lossy_count = r_cnt;

endmodule

// File: tb/tb_imm_narrow_buffer.sv
// Directed self-checking bench for imm_narrow_buffer; a second CNT_W=4
// instance shares the stimulus to exercise counter saturation.
module tb_imm_narrow_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sext;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_lossy;
  logic        clr_count;
  logic [15:0] lossy_count;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [9:0]  out_data_s;
  logic        out_lossy_s;
  logic [3:0]  lossy_count_s;

  int n_checks = 0;
  int n_errors = 0;

  imm_narrow_buffer #(.IN_W(32), .OUT_W(10), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sext(in_sext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lossy(out_lossy),
    .clr_count(clr_count), .lossy_count(lossy_count)
  );

  imm_narrow_buffer #(.IN_W(32), .OUT_W(10), .DEPTH(2), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_sext(in_sext),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_lossy(out_lossy_s),
    .clr_count(clr_count), .lossy_count(lossy_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word with the consumer stalled, check the head, then pop it.
  task automatic push_pop(input logic [31:0] d, input logic sx,
                          input logic [9:0] exp_d, input logic exp_l, input logic [15:0] exp_c);
    in_valid = 1'b1; in_data = d; in_sext = sx; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("head_valid", 32'(out_valid), 32'd1);
    check_eq("head_data",  32'(out_data),  32'(exp_d));
    check_eq("head_lossy", 32'(out_lossy), 32'(exp_l));
    check_eq("lossy_cnt",  32'(lossy_count), 32'(exp_c));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_sext = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    repeat (2) tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_data",  32'(out_data),  32'd0);
    check_eq("rst_out_lossy", 32'(out_lossy), 32'd0);
    check_eq("rst_count",     32'(lossy_count), 32'd0);
    reset = 1'b0;
    tick();

    push_pop(32'h0000_03FF, 1'b0, 10'h3FF, 1'b0, 16'd0);
    push_pop(32'h0000_0400, 1'b0, 10'h000, 1'b1, 16'd1);
    push_pop(32'hFFFF_FE00, 1'b1, 10'h200, 1'b0, 16'd1);
    push_pop(32'hFFFF_FC00, 1'b1, 10'h000, 1'b1, 16'd2);

    // Backpressure: A,B fill the buffer, C waits for space.
    in_valid = 1'b1; in_sext = 1'b0; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_data = 32'h33;
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("full_hold_rdy", 32'(in_ready), 32'd0);
    check_eq("order_A", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    check_eq("order_B", 32'(out_data), 32'h22);
    check_eq("after_pop_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("order_C", 32'(out_data), 32'h33);
    tick();
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Streaming at occupancy 1 across pointer wraps.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
    tick();
    out_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      in_data = 32'(k);
      check_eq("stream_data", 32'(out_data), 32'(k - 1));
      check_eq("stream_rdy",  32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check_eq("stream_last", 32'(out_data), 32'd8);
    tick();
    check_eq("stream_empty", 32'(out_valid), 32'd0);
    check_eq("stream_cnt",   32'(lossy_count), 32'd2);

    // Clear wins over the increment of a coincident lossy push.
    in_valid = 1'b1; in_data = 32'h0000_0400; in_sext = 1'b0;
    tick();
    check_eq("clr_pre1", 32'(lossy_count), 32'd3);
    tick();
    check_eq("clr_pre2", 32'(lossy_count), 32'd4);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_eq("clr_cnt", 32'(lossy_count), 32'd0);
    check_eq("clr_cnt_sat", 32'(lossy_count_s), 32'd0);

    // Seventeen lossy pushes saturate the narrow counter.
    in_data = 32'h0000_0800;
    repeat (17) tick();
    check_eq("sat_cnt4",  32'(lossy_count_s), 32'd15);
    check_eq("cnt16_17",  32'(lossy_count),   32'd17);

    // Fill to two entries, then reset between edges.
    out_ready = 1'b0; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_full", 32'(in_ready), 32'd0);
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_in_ready",  32'(in_ready),  32'd1);
    check_eq("arst_count",     32'(lossy_count), 32'd0);
    check_eq("arst_data",      32'(out_data),  32'd0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("post_rst_valid2", 32'(out_valid), 32'd0);
    check_eq("post_rst_cnt",    32'(lossy_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
